// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    // Sequencer modes; the unused encoding 2'd3 is treated as HALT.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } seq_state_t;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when the load in Execute writes a register that Decode reads.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use bubbles,
// taken-branch flushes, data-memory freeze with timeout watchdog.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_E,
    input  logic             MemRead_E,
    input  logic             PCSrc_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             mem_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    seq_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;
    logic              lu, mh;
    logic              freeze, resolve;

    assign lu = load_use(MemRead_E, rd_E, rs1_D, rs2_D);
    assign mh = dmem_req_M && !dmem_ready;

    // Next-state logic and combinational hazard outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        freeze    = 1'b0;
        resolve   = 1'b0;
        Stall_F   = 1'b0;
        Stall_D   = 1'b0;
        Stall_E   = 1'b0;
        Stall_M   = 1'b0;
        Flush_D   = 1'b0;
        Flush_E   = 1'b0;

        case (state_q)
            RUN: begin
                if (mh) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    // Freeze lifts: held instructions are re-evaluated this cycle.
                    resolve = 1'b1;
                    state_d = RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_q == TIMEOUT_CNT) begin
                        state_d   = HALT;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            default: begin
                // HALT and the unused encoding: frozen until reset.
                freeze = 1'b1;
            end
        endcase

        // Outputs are forced low while reset is held, regardless of inputs.
        if (!rst) begin
            if (freeze) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
            end else if (resolve) begin
                if (PCSrc_E) begin
                    // Decode holds a wrong-path instruction, so the branch wins over load-use.
                    Flush_D = 1'b1;
                    Flush_E = 1'b1;
                end else if (lu) begin
                    Stall_F = 1'b1;
                    Stall_D = 1'b1;
                    Flush_E = 1'b1;
                end
            end
        end
    end

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
    assign state_o = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (Stall_F),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (Flush_D),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer with a behavioural reference model.
module tb_hazard_sequencer;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    rs1_D, rs2_D, rd_E;
    logic          MemRead_E, PCSrc_E, dmem_req_M, dmem_ready;
    logic          Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
    logic          mem_err;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [5:0]    outs;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    hazard_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_D      (rs1_D),
        .rs2_D      (rs2_D),
        .rd_E       (rd_E),
        .MemRead_E  (MemRead_E),
        .PCSrc_E    (PCSrc_E),
        .dmem_req_M (dmem_req_M),
        .dmem_ready (dmem_ready),
        .Stall_F    (Stall_F),
        .Stall_D    (Stall_D),
        .Stall_E    (Stall_E),
        .Stall_M    (Stall_M),
        .Flush_D    (Flush_D),
        .Flush_E    (Flush_E),
        .mem_err    (mem_err),
        .state_o    (state_o),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    assign outs = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory freeze streak length, halted flag, counters.
    int   streak = 0;
    bit   halted = 1'b0;
    int   m_scnt = 0;
    int   m_fcnt = 0;
    bit   frozen;
    bit   lu_m;
    logic [5:0] exp_o;
    int   exp_state;

    always_comb begin
        lu_m      = MemRead_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
        frozen    = halted || ((streak > 0) ? !dmem_ready : (dmem_req_M && !dmem_ready));
        exp_o     = 6'b000000;
        exp_state = halted ? 2 : ((streak > 0) ? 1 : 0);
        if (frozen)       exp_o = 6'b111100;
        else if (PCSrc_E) exp_o = 6'b000011;
        else if (lu_m)    exp_o = 6'b110001;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= 0;
            halted <= 1'b0;
            m_scnt <= 0;
            m_fcnt <= 0;
        end else begin
            if (exp_o[5] && m_scnt < CMAX) m_scnt <= m_scnt + 1;
            if (exp_o[1] && m_fcnt < CMAX) m_fcnt <= m_fcnt + 1;
            if (!halted) begin
                if (frozen) begin
                    // Halt once memory has frozen the core for TIMEOUT+1 cycles in a row.
                    if (streak + 1 > TIMEOUT) halted <= 1'b1;
                    else                      streak <= streak + 1;
                end else begin
                    streak <= 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("model_outs",      32'(outs),      32'(exp_o));
            check("model_state",     32'(state_o),   exp_state);
            check("model_mem_err",   32'(mem_err),   32'(halted));
            check("model_stall_cnt", 32'(stall_cnt), m_scnt);
            check("model_flush_cnt", 32'(flush_cnt), m_fcnt);
        end
    end

    task automatic idle();
        rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
        MemRead_E = 1'b0; PCSrc_E = 1'b0; dmem_req_M = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        #12;
        check("reset_outs",      32'(outs),      0);
        check("reset_state",     32'(state_o),   0);
        check("reset_mem_err",   32'(mem_err),   0);
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        check("reset_flush_cnt", 32'(flush_cnt), 0);
        rst = 1'b0;
        tick();
        cmp_en = 1'b1;

        // Load-use on rs2 inserts exactly one bubble.
        MemRead_E = 1'b1; rd_E = 5'd5; rs1_D = 5'd3; rs2_D = 5'd5;
        @(negedge clk); check("lu_outs", 32'(outs), 32'(6'b110001));
        tick(); idle();
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        @(negedge clk); check("lu_one_bubble", 32'(outs), 0);
        tick();

        // Load to x0 never stalls.
        MemRead_E = 1'b1; rd_E = 5'd0; rs1_D = 5'd0; rs2_D = 5'd0;
        @(negedge clk); check("lu_x0_outs", 32'(outs), 0);
        tick(); idle();
        check("lu_x0_stall_cnt", 32'(stall_cnt), 1);

        // Taken branch overrides a simultaneous load-use.
        PCSrc_E = 1'b1; MemRead_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
        @(negedge clk); check("br_lu_outs", 32'(outs), 32'(6'b000011));
        tick(); idle();
        check("br_flush_cnt", 32'(flush_cnt), 1);
        check("br_stall_cnt", 32'(stall_cnt), 1);

        // Stray ready pulse without a request is ignored.
        dmem_ready = 1'b1;
        @(negedge clk); check("ready_pulse_outs", 32'(outs), 0);
        tick(); idle();
        check("ready_pulse_state", 32'(state_o), 0);

        // Memory wait: three frozen cycles, branch suppressed while frozen,
        // then honoured in the ready cycle.
        do_reset();
        dmem_req_M = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); check("mw_c1", 32'({state_o, outs}), 32'({2'd0, 6'b111100}));
        tick();
        PCSrc_E = 1'b1;
        @(negedge clk); check("mw_c2", 32'({state_o, outs}), 32'({2'd1, 6'b111100}));
        tick();
        PCSrc_E = 1'b0;
        @(negedge clk); check("mw_c3", 32'({state_o, outs}), 32'({2'd1, 6'b111100}));
        tick();
        dmem_ready = 1'b1; PCSrc_E = 1'b1;
        @(negedge clk); check("mw_ready", 32'({state_o, outs}), 32'({2'd1, 6'b000011}));
        tick(); idle();
        check("mw_state_run", 32'(state_o),   0);
        check("mw_stall_cnt", 32'(stall_cnt), 3);
        check("mw_flush_cnt", 32'(flush_cnt), 1);

        // Timeout: HALT after the fifth stall cycle, then frozen for good.
        do_reset();
        dmem_req_M = 1'b1; dmem_ready = 1'b0;
        repeat (4) tick();
        check("to_pre_state",   32'(state_o), 1);
        check("to_pre_mem_err", 32'(mem_err), 0);
        tick();
        check("to_state",   32'(state_o), 2);
        check("to_mem_err", 32'(mem_err), 1);
        for (int i = 0; i < 20; i++) begin
            dmem_ready = i[0];
            PCSrc_E    = i[1];
            @(negedge clk); check("halt_outs", 32'(outs), 32'(6'b111100));
            tick();
        end
        check("halt_state",     32'(state_o),   2);
        check("halt_stall_sat", 32'(stall_cnt), 15);

        // Asynchronous reset in the middle of a memory wait.
        do_reset();
        dmem_req_M = 1'b1; dmem_ready = 1'b0;
        tick(); tick();
        check("rmw_in_wait", 32'(state_o), 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("rmw_outs",      32'(outs),      0);
        check("rmw_state",     32'(state_o),   0);
        check("rmw_stall_cnt", 32'(stall_cnt), 0);
        check("rmw_mem_err",   32'(mem_err),   0);
        rst = 1'b0;
        idle();
        tick();
        check("rmw_no_pending", 32'(state_o), 0);

        // Saturation: a permanent load-use stalls every cycle.
        do_reset();
        MemRead_E = 1'b1; rd_E = 5'd9; rs1_D = 5'd9;
        repeat (20) tick();
        check("sat_stall_cnt", 32'(stall_cnt), 15);
        idle();
        tick();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central stall/flush controller for the 5-stage pipelined RV32 core. It detects load-use hazards between the Decode and Execute stages, flushes wrong-path instructions on taken branches, and freezes the whole pipeline while data memory holds off a request. A timeout watchdog halts the core on a hung memory, and saturating counters record stall and flush activity.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive wait cycles in MEM_WAIT before HALT (minimum 1)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
rs1_D  in  5  Decode-stage source register 1 (Ins_D[19:15])
rs2_D  in  5  Decode-stage source register 2 (Ins_D[24:20])
rd_E  in  5  Execute-stage destination register
MemRead_E  in  1  Execute-stage instruction is a load
PCSrc_E  in  1  branch/jump resolved taken in Execute
dmem_req_M  in  1  Memory stage issues a data-memory access this cycle
dmem_ready  in  1  data memory completes the access this cycle
Stall_F  out  1  hold the PC
Stall_D  out  1  hold the IF/ID register
Stall_E  out  1  hold the ID/EX register
Stall_M  out  1  hold the EX/MEM register
Flush_D  out  1  clear the IF/ID register to a bubble
Flush_E  out  1  clear the ID/EX register to a bubble (control bits 0)
mem_err  out  1  sticky; memory timeout occurred
state_o  out  2  current FSM state
stall_cnt  out  CNT_W  cycles in which Stall_F=1
flush_cnt  out  CNT_W  cycles in which Flush_D=1

Behaviour:
- Reset (asynchronous, while rst=1): state=RUN, mem_err=0, wait counter=0, stall_cnt=0, flush_cnt=0. All Stall_* and Flush_* outputs are 0.
- The hazard outputs are combinational from the state and inputs. The state, counters and mem_err are registered.
- Load-use condition: lu = MemRead_E & (rd_E!=0) & (rd_E==rs1_D | rd_E==rs2_D).
- Memory hold condition: mh = dmem_req_M & ~dmem_ready.
- RUN, evaluated in priority order:
  1. mh: Stall_F=Stall_D=Stall_E=Stall_M=1 and both flushes 0. Next state MEM_WAIT with wait counter=1.
  2. PCSrc_E: Flush_D=Flush_E=1 and all stalls 0. Branch has priority over lu because the Decode instruction is wrong-path.
  3. lu: Stall_F=Stall_D=1, Flush_E=1, Stall_E=Stall_M=0. This inserts exactly one bubble; next cycle the load is in M and lu is normally clear.
  4. Otherwise all outputs are 0.
- MEM_WAIT:
  - While dmem_ready=0, all four stalls are 1, flushes are 0, and the wait counter increments.
  - When dmem_ready=1, all stalls drop in that same cycle, the RUN rules for PCSrc_E and lu apply in that cycle, and the next state is RUN.
  - Branch and load-use are suppressed while frozen. The held instructions re-evaluate once the freeze lifts, so no branch is lost.
  - If dmem_ready=0 and the wait counter equals MEM_TIMEOUT: next state HALT and mem_err is set to 1.
- HALT: all four stalls are 1 and flushes are 0 permanently. The only exit is rst.
- A dmem_ready pulse in RUN with dmem_req_M=0 is ignored.
- rst asserted in any state, including mid-wait, returns immediately to the reset values with no pending state retained.
- stall_cnt increments on each clk edge where Stall_F=1; flush_cnt increments on each edge where Flush_D=1. Both saturate at 2^CNT_W-1 and do not wrap.
- The wait counter is $clog2(MEM_TIMEOUT+1) bits wide.

Decomposition:
- hazard_pkg holds:
  - typedef enum logic [1:0] seq_state_t, with RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2 (2'd3 is unused and decodes as HALT);
  - the REG_ZERO=5'd0 constant.
- One sub-module, sat_counter (parameter W, inputs clk/rst/inc, output count, saturating), instantiated twice for the performance counters.

Test Plan:
- Load-use: MemRead_E=1, rd_E=5, rs2_D=5 for one cycle -> Stall_F=Stall_D=Flush_E=1 for exactly 1 cycle; stall_cnt=1. Repeat with rd_E=0 -> no stall.
- Taken branch plus simultaneous load-use: PCSrc_E=1 with the load-use condition true -> Flush_D=Flush_E=1, Stall_F=0; flush_cnt=1.
- Memory wait: dmem_req_M=1, dmem_ready low for 3 cycles then high -> all stalls=1 for 3 cycles, state_o=1, then RUN with stalls 0 in the ready cycle; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, dmem_req_M=1, dmem_ready held at 0 -> state_o=2 and mem_err=1 after the 5th stall cycle, and stalls stay 1 for 20 further cycles.
- Reset mid-wait: assert rst during MEM_WAIT -> outputs 0 and state_o=0 asynchronously, before the next clk edge; counters read 0.
- Saturation: CNT_W=4, hold the load-use condition for 20 cycles -> stall_cnt stops at 15.
